// File: rtl/icache_data_array.sv
// Instruction-cache data store: WAYS x 2**SET_BITS lines of WORDS_PER_LINE words,
// a beat-by-beat refill engine that commits whole lines, and one-cycle registered fetch reads.
module icache_data_array #(
  parameter int DATA_WIDTH     = 32,
  parameter int WAYS           = 2,
  parameter int SET_BITS       = 7,
  parameter int WORDS_PER_LINE = 8,
  localparam int WAY_BITS      = (WAYS > 1) ? $clog2(WAYS) : 1,
  localparam int OFF_BITS      = $clog2(WORDS_PER_LINE)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       rd_en,
  input  logic [SET_BITS-1:0]        rd_set,
  input  logic [OFF_BITS-1:0]        rd_word,
  output logic [WAYS*DATA_WIDTH-1:0] rd_data,
  output logic                       rd_valid,
  input  logic                       fill_start,
  input  logic [SET_BITS-1:0]        fill_set,
  input  logic [WAY_BITS-1:0]        fill_way,
  output logic                       fill_busy,
  input  logic                       beat_valid,
  input  logic [DATA_WIDTH-1:0]      beat_data,
  input  logic                       beat_last,
  output logic                       beat_ready,
  output logic                       fill_done,
  output logic                       fill_err
);

  localparam int SETS = 2 ** SET_BITS;
  localparam logic [OFF_BITS-1:0] LAST_BEAT = OFF_BITS'(WORDS_PER_LINE - 1);

  typedef enum logic [1:0] {IDLE, FILL, COMMIT} state_t;

  state_t                state, state_next;
  logic [OFF_BITS-1:0]   cnt;
  logic [SET_BITS-1:0]   lat_set;
  logic [WAY_BITS-1:0]   lat_way;
  logic [DATA_WIDTH-1:0] line_buf [WORDS_PER_LINE];
  logic [DATA_WIDTH-1:0] mem [WAYS][SETS][WORDS_PER_LINE];
  logic                  beat_take, beat_good, beat_bad;
  logic [WAYS*DATA_WIDTH-1:0] rd_next;

  assign beat_ready = (state == FILL);
  assign fill_busy  = (state == FILL) || (state == COMMIT);
  assign beat_take  = beat_valid && beat_ready;
  // A burst is good only if beat_last lands exactly on the final word slot.
  assign beat_good  = beat_take && beat_last && (cnt == LAST_BEAT);
  assign beat_bad   = beat_take && (beat_last != (cnt == LAST_BEAT));

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (fill_start) state_next = FILL;
      FILL: begin
        if (beat_good)     state_next = COMMIT;
        else if (beat_bad) state_next = IDLE;
      end
      COMMIT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      lat_set   <= '0;
      lat_way   <= '0;
      fill_done <= 1'b0;
      fill_err  <= 1'b0;
    end else begin
      fill_done <= (state == COMMIT) || beat_bad;
      fill_err  <= beat_bad;
      if (state == IDLE && fill_start) begin
        lat_set <= fill_set;
        lat_way <= fill_way;
        cnt     <= '0;
      end else if (beat_take && !beat_good && !beat_bad) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // NOTE: storage arrays carry no reset; contents are only meaningful once a line has been committed.
  always_ff @(posedge clk) begin
    if (beat_take) line_buf[cnt] <= beat_data;
    if (state == COMMIT) begin
      for (int w = 0; w < WORDS_PER_LINE; w++)
        mem[lat_way][lat_set][OFF_BITS'(w)] <= line_buf[OFF_BITS'(w)];
    end
  end

  // Write-first bypass: the way being committed this cycle returns the new word.
  always_comb begin
    rd_next = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (state == COMMIT && lat_set == rd_set && lat_way == WAY_BITS'(w))
        rd_next[w*DATA_WIDTH +: DATA_WIDTH] = line_buf[rd_word];
      else
        rd_next[w*DATA_WIDTH +: DATA_WIDTH] = mem[w][rd_set][rd_word];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= rd_next;
    end
  end

endmodule
